// File: rtl/mul_seq_radix4_if.sv
// Operand and product handshake bundle for mul_seq_radix4.
// The master side produces operands and consumes products; the slave side is the multiplier.
interface mul_seq_radix4_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/mul_seq_radix4.sv
// Iterative WIDTHxWIDTH radix-4 multiplier, one 2-bit multiplier digit per cycle, LSB digit first.
// Signed mode weights the top digit negatively, so two's-complement products come out exact.
module mul_seq_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mul_seq_radix4_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NDIG - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("mul_seq_radix4: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic              r_signed;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_out;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_last;
    logic [PW-1:0]     w_pp;
    logic [PW-1:0]     w_acc_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise an untaken branch infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_BUSY;
            S_BUSY:  if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = !rst;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = w_in_ready && bus.in_valid;
    assign w_last   = (r_cnt == LAST_K);

    // Digit weight is b0 + 2*b1, except the top signed digit where the 2*b1 term is negative.
    always_comb begin
        w_pp = '0;
        if (r_mplier[0]) begin
            w_pp = r_mcand;
        end
        if (r_mplier[1]) begin
            if (r_signed && w_last) begin
                w_pp = w_pp - (r_mcand << 1);
            end else begin
                w_pp = w_pp + (r_mcand << 1);
            end
        end
    end

    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_out    <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
            r_mplier <= bus.b;
            r_signed <= bus.is_signed;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else if (r_state == S_BUSY) begin
            // Multiplicand pre-shifted by two each digit instead of a variable shift by 2k.
            r_mcand  <= r_mcand << 2;
            r_mplier <= r_mplier >> 2;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_next;
            if (w_last) begin
                r_out <= w_acc_next;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out       = r_out;
endmodule
